fetch_pc_gen: RTL and testbench

//  Fetch-stage next-PC generator. Sits directly upstream of the BTB.

---
 rtl/fetch_pc_gen.sv | 136 +++++++++++++
 tb/tb_fetch_pc_gen.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_gen.sv
// ---------------------------------------------------------------------------
// fetch_pc_gen
//
// Fetch-stage next-PC generator sitting directly upstream of the BTB. It owns
// the PC register that addresses both the BTB and instruction memory, and each
// cycle picks the next PC from: reset vector, EX redirect, predicted target,
// or sequential PC+4.
//
// Optional feature macro: FETCH_BHT_EN
//   defined   : a 2-bit saturating-counter direction table (BHT) gates BTB hits
//   undefined : no BHT storage, every BTB hit is predicted taken and the
//               upd_* training inputs are ignored
//
// Parameters
//   RESET_PC   : PC loaded by reset (bits [1:0] must be zero)
//   BHT_IDX_W  : BHT index width, index = PC[BHT_IDX_W+1:2]
//
// Ports
//   clk            : clock, all state updates on posedge
//   reset          : synchronous active-high reset
//   stall          : downstream backpressure, hold PC
//   redirect_valid : EX resolved a mispredict, load redirect_pc
//   redirect_pc    : corrected fetch address
//   btb_hit        : BTB hit for the current PC
//   btb_target     : BTB predicted target for the current PC
//   upd_valid      : BHT training strobe for a resolved conditional branch
//   upd_pc         : PC of the resolved branch
//   upd_taken      : actual direction of the resolved branch
//   PC             : current fetch PC
//   fetch_valid    : current PC is a real fetch, not a reset bubble
//   pred_taken     : current PC is predicted taken (combinational)
//   pred_target    : word-aligned predicted target for the current PC
//   redirect_count : saturating count of accepted redirects
// ---------------------------------------------------------------------------
module fetch_pc_gen #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BHT_IDX_W = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        btb_hit,
   input  logic [31:0] btb_target,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   output logic [31:0] PC,
   output logic        fetch_valid,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   output logic [15:0] redirect_count
);

   logic        dir;
   logic [31:0] next_pc;

`ifdef FETCH_BHT_EN
   logic [1:0]           bht [2**BHT_IDX_W];
   logic [BHT_IDX_W-1:0] rd_idx;
   logic [BHT_IDX_W-1:0] wr_idx;
   logic                 unused_bits;

   assign rd_idx = PC[BHT_IDX_W+1:2];
   assign wr_idx = upd_pc[BHT_IDX_W+1:2];

   // Lookup reads the registered counter, so a same-cycle update to the same
   // entry only becomes visible on the following cycle.
   assign dir = bht[rd_idx][1];

   // Counter training; saturates at both ends. Reset returns every entry to
   // weakly not-taken and discards any update presented in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 2**BHT_IDX_W; i++) begin
            bht[i] <= 2'b01;
         end
      end else if (upd_valid) begin
         if (upd_taken) begin
            if (bht[wr_idx] != 2'b11) begin
               bht[wr_idx] <= bht[wr_idx] + 2'b01;
            end
         end else begin
            if (bht[wr_idx] != 2'b00) begin
               bht[wr_idx] <= bht[wr_idx] - 2'b01;
            end
         end
      end
   end

   assign unused_bits = ^{upd_pc[31:BHT_IDX_W+2], upd_pc[1:0],
                          btb_target[1:0], redirect_pc[1:0]};
`else
   logic unused_bits;

   // Without a direction table every BTB hit is taken.
   assign dir = 1'b1;

   assign unused_bits = ^{upd_valid, upd_pc, upd_taken,
                          btb_target[1:0], redirect_pc[1:0]};
`endif

   assign pred_taken  = btb_hit & dir;
   assign pred_target = {btb_target[31:2], 2'b00};

   // Next-PC selection. The first cycle after reset (fetch_valid still 0) is
   // a bubble that holds RESET_PC, so RESET_PC is the first real fetch. A
   // redirect outranks both the bubble hold and a stall.
   always_comb begin
      next_pc = PC + 32'd4;
      if (redirect_valid) begin
         next_pc = {redirect_pc[31:2], 2'b00};
      end else if (stall || !fetch_valid) begin
         next_pc = PC;
      end else if (pred_taken) begin
         next_pc = pred_target;
      end
   end

   // PC register, reset-bubble flag and saturating redirect counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         PC             <= RESET_PC;
         fetch_valid    <= 1'b0;
         redirect_count <= 16'h0000;
      end else begin
         PC          <= next_pc;
         fetch_valid <= 1'b1;
         if (redirect_valid && (redirect_count != 16'hFFFF)) begin
            redirect_count <= redirect_count + 16'h0001;
         end
      end
   end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_fetch_pc_gen
//
// Self-checking bench for fetch_pc_gen. A behavioural model (plain integers
// and an array of counters) tracks PC, fetch_valid, the redirect count and,
// when FETCH_BHT_EN is defined, the direction table. Directed scenarios are
// followed by a randomized phase and a redirect-counter saturation run.
// ---------------------------------------------------------------------------
module tb_fetch_pc_gen;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        btb_hit = 1'b0;
   logic [31:0] btb_target = '0;
   logic        upd_valid = 1'b0;
   logic [31:0] upd_pc = '0;
   logic        upd_taken = 1'b0;
   logic [31:0] PC;
   logic        fetch_valid;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic [15:0] redirect_count;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [31:0] m_pc;
   logic        m_fv;
   int          m_cnt;
   int          m_bht [256];

   fetch_pc_gen #(.RESET_PC(RESET_PC), .BHT_IDX_W(8)) dut (
      .clk(clk), .reset(reset), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .btb_hit(btb_hit), .btb_target(btb_target),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .PC(PC), .fetch_valid(fetch_valid), .pred_taken(pred_taken),
      .pred_target(pred_target), .redirect_count(redirect_count)
   );

   always #5 clk = ~clk;

   // Compare one observed value against its expected value.
   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic model_dir();
`ifdef FETCH_BHT_EN
      return m_bht[m_pc[9:2]] >= 2;
`else
      return 1'b1;
`endif
   endfunction

   // One clock of stimulus: drive inputs after the falling edge, check the
   // combinational outputs, advance the model, then check registered state.
   task automatic applyStimulus(input logic rst, input logic st,
                                input logic rv, input logic [31:0] rpc,
                                input logic hit, input logic [31:0] tgt,
                                input logic uv, input logic [31:0] upc,
                                input logic ut);
      logic m_pred;
      @(negedge clk);
      reset = rst; stall = st; redirect_valid = rv; redirect_pc = rpc;
      btb_hit = hit; btb_target = tgt; upd_valid = uv; upd_pc = upc;
      upd_taken = ut;
      #1;
      m_pred = hit & model_dir();
      checkOutput("pred_taken", {31'b0, pred_taken}, {31'b0, m_pred});
      checkOutput("pred_target", pred_target, tgt & 32'hFFFF_FFFC);

      if (rst) begin
         m_pc  = RESET_PC;
         m_fv  = 1'b0;
         m_cnt = 0;
         for (int i = 0; i < 256; i++) m_bht[i] = 1;
      end else begin
         if (rv) begin
            m_pc = rpc & 32'hFFFF_FFFC;
            if (m_cnt < 65535) m_cnt++;
         end else if (st || !m_fv) begin
            m_pc = m_pc;
         end else if (m_pred) begin
            m_pc = tgt & 32'hFFFF_FFFC;
         end else begin
            m_pc = m_pc + 32'd4;
         end
         m_fv = 1'b1;
`ifdef FETCH_BHT_EN
         if (uv) begin
            if (ut) m_bht[upc[9:2]] = (m_bht[upc[9:2]] == 3) ? 3 : m_bht[upc[9:2]] + 1;
            else    m_bht[upc[9:2]] = (m_bht[upc[9:2]] == 0) ? 0 : m_bht[upc[9:2]] - 1;
         end
`endif
      end

      @(posedge clk);
      #1;
      checkOutput("PC", PC, m_pc);
      checkOutput("fetch_valid", {31'b0, fetch_valid}, {31'b0, m_fv});
      checkOutput("redirect_count", {16'b0, redirect_count}, m_cnt[31:0]);
   endtask

   task automatic idle();
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic doReset();
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic redirectTo(input logic [31:0] a);
      applyStimulus(1'b0, 1'b0, 1'b1, a, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
   endtask

   initial begin
      m_pc = RESET_PC; m_fv = 1'b0; m_cnt = 0;
      for (int i = 0; i < 256; i++) m_bht[i] = 1;

      // Reset and the first sequential fetches
      $display("[TB] reset and sequential fetch");
      doReset();
      checkOutput("reset_pc", PC, 32'h0);
      checkOutput("reset_fv", {31'b0, fetch_valid}, 32'h0);
      checkOutput("reset_cnt", {16'b0, redirect_count}, 32'h0);
      idle();
      checkOutput("first_pc", PC, 32'h0);
      checkOutput("first_fv", {31'b0, fetch_valid}, 32'h1);
      idle();
      checkOutput("seq_pc4", PC, 32'h4);
      idle();
      checkOutput("seq_pc8", PC, 32'h8);

      // BTB hit at PC=0x8
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
`ifndef FETCH_BHT_EN
      checkOutput("btb_taken_pc", PC, 32'h100);
`else
      checkOutput("bht_weak_pc", PC, 32'hC);
`endif

      // Stall and redirect under stall
      $display("[TB] stall and redirect");
      doReset();
      for (int i = 0; i < 5; i++) idle();
      checkOutput("pre_stall_pc", PC, 32'h10);
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h500, 1'b0, 32'h0, 1'b0);
      checkOutput("stall_hold_pc", PC, 32'h10);
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h203, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      checkOutput("stall_redirect_pc", PC, 32'h200);
      checkOutput("stall_redirect_cnt", {16'b0, redirect_count}, 32'h1);

      // Redirect beats a predicted-taken BTB hit
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h300, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
      checkOutput("redirect_over_hit", PC, 32'h300);

`ifdef FETCH_BHT_EN
      // Direction table training and saturation
      $display("[TB] BHT training");
      redirectTo(32'h40);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h800, 1'b1, 32'h40, 1'b1);
      checkOutput("bht_weak_nt_pc", PC, 32'h44);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1);
      redirectTo(32'h40);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h800, 1'b0, 32'h0, 1'b0);
      checkOutput("bht_strong_t_pc", PC, 32'h800);
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b1);
      redirectTo(32'h40);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h800, 1'b0, 32'h0, 1'b0);
      checkOutput("bht_sat_low_pc", PC, 32'h44);
`endif

      // Randomized phase; addresses kept in a small window so BHT entries collide
      $display("[TB] random phase");
      for (int i = 0; i < 2000; i++) begin
         applyStimulus(($urandom_range(0, 99) == 0),
                       ($urandom_range(0, 4) == 0),
                       ($urandom_range(0, 9) == 0),
                       $urandom_range(0, 255),
                       $urandom_range(0, 1),
                       $urandom_range(0, 255),
                       $urandom_range(0, 1),
                       $urandom_range(0, 255),
                       $urandom_range(0, 1));
      end

      // Redirect counter saturation
      $display("[TB] redirect count saturation");
      doReset();
      for (int i = 0; i < 65537; i++) redirectTo(32'h1000);
      checkOutput("cnt_saturated", {16'b0, redirect_count}, 32'h0000_FFFF);
      redirectTo(32'h1000);
      checkOutput("cnt_holds", {16'b0, redirect_count}, 32'h0000_FFFF);

      // PC wraps modulo 2**32
      redirectTo(32'hFFFF_FFFC);
      idle();
      checkOutput("pc_wrap", PC, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
